// File: rtl/shift_unit.sv
// Sequential barrel-free shifter: shifts or rotates the operand one bit per clock,
// reporting the last bit moved out and whether the result is zero.
`timescale 1ns/1ps
module shift_unit #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   amount,
    input  logic [WIDTH-1:0] operand,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL} mode_t;

    state_t           state;
    state_t           next_state;
    mode_t            mode_q;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] shifted;
    logic             shift_carry;
    logic             accept;

    assign accept = (state == IDLE) && start;
    assign zero   = (result == '0);

    // One-bit step of the latched operation, applied to the current result.
    always_comb begin
        shifted     = result;
        shift_carry = 1'b0;
        case (mode_q)
            MODE_SLL: begin
                shifted     = {result[WIDTH-2:0], 1'b0};
                shift_carry = result[WIDTH-1];
            end
            MODE_SRL: begin
                shifted     = {1'b0, result[WIDTH-1:1]};
                shift_carry = result[0];
            end
            MODE_SRA: begin
                shifted     = {result[WIDTH-1], result[WIDTH-1:1]};
                shift_carry = result[0];
            end
            MODE_ROL: begin
                shifted     = {result[WIDTH-2:0], result[WIDTH-1]};
                shift_carry = result[WIDTH-1];
            end
            default: begin
                shifted     = result;
                shift_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = (amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == SHW'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Result and carry persist outside SHIFT so they stay readable after DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carry_out <= 1'b0;
            mode_q    <= MODE_SLL;
            cnt       <= '0;
        end else if (accept) begin
            result    <= operand;
            carry_out <= 1'b0;
            mode_q    <= mode_t'(mode);
            cnt       <= amount;
        end else if (state == SHIFT) begin
            result    <= shifted;
            carry_out <= shift_carry;
            cnt       <= cnt - SHW'(1);
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed vector table, hand-written
// busy/reset sequences, and random operations against an arithmetic model.
`timescale 1ns/1ps
module tb_shift_unit;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       mode;
    logic [SHW-1:0]   amount;
    logic [WIDTH-1:0] operand;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]       m;
        int               amt;
        logic [WIDTH-1:0] op;
        logic [WIDTH-1:0] res;
        logic             cy;
    } vec_t;

    vec_t vecs[12];

    shift_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .operand   (operand),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: the whole shift computed at once from the mode definitions.
    function automatic void refShift(input logic [1:0] m, input int amt,
                                     input logic [WIDTH-1:0] op,
                                     output logic [WIDTH-1:0] res, output logic cy);
        logic signed [WIDTH-1:0] s;
        s = op;
        case (m)
            2'd0:    res = op << amt;
            2'd1:    res = op >> amt;
            2'd2:    res = s >>> amt;
            default: res = (amt == 0) ? op : ((op << amt) | (op >> (WIDTH - amt)));
        endcase
        if (amt == 0)      cy = 1'b0;
        else if (m == 2'd0) cy = op[WIDTH-amt];
        else if (m == 2'd3) cy = res[0];
        else                cy = op[amt-1];
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, " ready"},  {15'd0, ready},     16'd1);
        checkOutput({tag, " busy"},   {15'd0, busy},      16'd0);
        checkOutput({tag, " done"},   {15'd0, done},      16'd0);
        checkOutput({tag, " result"}, result,             16'd0);
        checkOutput({tag, " carry"},  {15'd0, carry_out}, 16'd0);
        checkOutput({tag, " zero"},   {15'd0, zero},      16'd1);
    endtask

    // Called just after a negedge; returns just after the negedge following DONE.
    task automatic applyStimulus(input logic [1:0] m, input int amt,
                                 input logic [WIDTH-1:0] op,
                                 input logic [WIDTH-1:0] exp_res, input logic exp_cy,
                                 input string name);
        int cyc;
        bit seen;
        bit busy_bad;
        checkOutput({name, " ready before start"}, {15'd0, ready}, 16'd1);
        start   = 1'b1;
        mode    = m;
        amount  = SHW'(amt);
        operand = op;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mode    = 2'($urandom);
        amount  = SHW'($urandom);
        operand = WIDTH'($urandom);
        cyc      = 0;
        seen     = 1'b0;
        busy_bad = 1'b0;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (!busy || ready) busy_bad = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: no done within %0d cycles, expected done at %0d",
                     name, cyc, amt + 1);
        end else begin
            checkOutput({name, " latency"}, WIDTH'(cyc), WIDTH'(amt + 1));
            checkOutput({name, " busy during op"}, {15'd0, busy_bad}, 16'd0);
            checkOutput({name, " busy in done"}, {15'd0, busy}, 16'd1);
            checkOutput({name, " result"}, result, exp_res);
            checkOutput({name, " carry"}, {15'd0, carry_out}, {15'd0, exp_cy});
            checkOutput({name, " zero"}, {15'd0, zero}, {15'd0, exp_res == '0});
            @(negedge clk);
            checkOutput({name, " done one cycle"}, {15'd0, done}, 16'd0);
            checkOutput({name, " ready after"}, {15'd0, ready}, 16'd1);
            checkOutput({name, " result held"}, result, exp_res);
            checkOutput({name, " carry held"}, {15'd0, carry_out}, {15'd0, exp_cy});
        end
    endtask

    initial begin
        logic [WIDTH-1:0] rres;
        logic             rcy;
        logic [1:0]       rm;
        int               ramt;
        logic [WIDTH-1:0] rop;
        int               done_count;
        logic [WIDTH-1:0] done_res;
        int               done_cyc;

        vecs[0]  = '{2'd0,  4, 16'h0003, 16'h0030, 1'b0};
        vecs[1]  = '{2'd2,  1, 16'h8001, 16'hC000, 1'b1};
        vecs[2]  = '{2'd1,  1, 16'h8001, 16'h4000, 1'b1};
        vecs[3]  = '{2'd3,  4, 16'h8001, 16'h0018, 1'b0};
        vecs[4]  = '{2'd0,  1, 16'h8000, 16'h0000, 1'b1};
        vecs[5]  = '{2'd1,  0, 16'h00F0, 16'h00F0, 1'b0};
        vecs[6]  = '{2'd2, 15, 16'h8000, 16'hFFFF, 1'b0};
        vecs[7]  = '{2'd3, 15, 16'h0002, 16'h0001, 1'b1};
        vecs[8]  = '{2'd0, 15, 16'hFFFF, 16'h8000, 1'b1};
        vecs[9]  = '{2'd1, 15, 16'h8000, 16'h0001, 1'b0};
        vecs[10] = '{2'd2,  3, 16'h7FFF, 16'h0FFF, 1'b1};
        vecs[11] = '{2'd3,  0, 16'h1234, 16'h1234, 1'b0};

        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = 2'd0;
        amount  = '0;
        operand = '0;
        #1;
        checkReset("initial reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].m, vecs[i].amt, vecs[i].op, vecs[i].res, vecs[i].cy,
                          $sformatf("vec%0d", i));
        end

        // start pulsed with new operands while busy must be ignored, not queued
        start   = 1'b1;
        mode    = 2'd0;
        amount  = 4'd4;
        operand = 16'h0003;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_count = 0;
        done_res   = '0;
        done_cyc   = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start   = 1'b1;
                mode    = 2'd3;
                amount  = 4'd1;
                operand = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_count++;
                done_res = result;
                done_cyc = c;
            end
        end
        checkOutput("busy start done count", WIDTH'(done_count), 16'd1);
        checkOutput("busy start result", done_res, 16'h0030);
        checkOutput("busy start latency", WIDTH'(done_cyc), 16'd5);

        // reset in the 2nd SHIFT cycle of an amount-8 operation
        start   = 1'b1;
        mode    = 2'd0;
        amount  = 4'd8;
        operand = 16'h00FF;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre-reset busy", {15'd0, busy}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("mid-op reset");
        done_count = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_count++;
        end
        checkOutput("reset no done", WIDTH'(done_count), 16'd0);
        checkReset("reset held");
        rst_n = 1'b1;
        applyStimulus(2'd0, 1, 16'h0001, 16'h0002, 1'b0, "post-reset sll");

        for (int i = 0; i < 150; i++) begin
            rm   = 2'($urandom_range(0, 3));
            ramt = int'($urandom_range(0, WIDTH - 1));
            rop  = WIDTH'($urandom);
            refShift(rm, ramt, rop, rres, rcy);
            applyStimulus(rm, ramt, rop, rres, rcy, $sformatf("rand%0d", i));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
